// File: rtl/lstm_mm_pkg.sv
// Shared parameters and types for the matrix-multiplication datapath.
// Tile fetch supports optional edge padding via the TILE_EDGE_PAD_EN macro.
package lstm_mm_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int ADDR_WIDTH = 9;
  localparam int TILE_DIM   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/tile_addr_gen.sv
// Row/column walker for one tile: tracks (r,c), the running row base address,
// the local tile index and, with TILE_EDGE_PAD_EN defined, whether the current
// element lies outside the valid region and must be zero-padded.
module tile_addr_gen
  import lstm_mm_pkg::*;
#(
  parameter int ADDR_WIDTH = lstm_mm_pkg::ADDR_WIDTH,
  parameter int TILE_DIM   = lstm_mm_pkg::TILE_DIM,
  parameter int LT_AW      = $clog2(TILE_DIM*TILE_DIM),
  parameter int VW         = $clog2(TILE_DIM+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  input  logic [VW-1:0]         valid_rows,
  input  logic [VW-1:0]         valid_cols,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [LT_AW-1:0]      idx,
  output logic                  pad,
  output logic                  last
);

  localparam int N = TILE_DIM * TILE_DIM;

  logic [VW-1:0]         r;
  logic [VW-1:0]         c;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] stride_q;

  // Walk the tile in row-major order; addresses wrap modulo 2^ADDR_WIDTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r        <= '0;
      c        <= '0;
      idx      <= '0;
      row_base <= '0;
      stride_q <= '0;
      addr     <= '0;
    end else if (load) begin
      r        <= '0;
      c        <= '0;
      idx      <= '0;
      row_base <= base_addr;
      stride_q <= row_stride;
      addr     <= base_addr;
    end else if (advance) begin
      idx <= idx + LT_AW'(1);
      if (c == VW'(TILE_DIM-1)) begin
        c        <= '0;
        r        <= r + VW'(1);
        row_base <= row_base + stride_q;
        addr     <= row_base + stride_q;
      end else begin
        c    <= c + VW'(1);
        addr <= addr + ADDR_WIDTH'(1);
      end
    end
  end

  assign last = (idx == LT_AW'(N-1));

`ifdef TILE_EDGE_PAD_EN
  logic [VW-1:0] rows_q;
  logic [VW-1:0] cols_q;

  // Capture the in-bounds extent at start so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rows_q <= '0;
      cols_q <= '0;
    end else if (load) begin
      rows_q <= valid_rows;
      cols_q <= valid_cols;
    end
  end

  assign pad = (r >= rows_q) || (c >= cols_q);
`else
  // Extent inputs have no effect without padding; every element is read.
  logic unused_extent;
  assign unused_extent = ^{valid_rows, valid_cols};
  assign pad = 1'b0;
`endif

endmodule

// File: rtl/tile_fetch.sv
// Tile fetch: copies one TILE_DIM x TILE_DIM tile from row-major global memory
// into the local tile memory, one element per non-held cycle, then pulses done.
// Optional edge zero-padding is enabled with the TILE_EDGE_PAD_EN macro.
//
// Handshake: start is accepted only in IDLE; gm_rd_en marks a read whose data
// arrives on gm_rd_data exactly one cycle later, at which point lt_wr_en is
// high with lt_addr/lt_data for that element. hold suppresses issue in FETCH.
module tile_fetch
  import lstm_mm_pkg::*;
#(
  parameter int DATA_WIDTH = lstm_mm_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = lstm_mm_pkg::ADDR_WIDTH,
  parameter int TILE_DIM   = lstm_mm_pkg::TILE_DIM,
  parameter int LT_AW      = $clog2(TILE_DIM*TILE_DIM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           hold,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH-1:0]          row_stride,
  input  logic [$clog2(TILE_DIM+1)-1:0]  valid_rows,
  input  logic [$clog2(TILE_DIM+1)-1:0]  valid_cols,
  output logic                           gm_rd_en,
  output logic [ADDR_WIDTH-1:0]          gm_addr,
  input  logic [DATA_WIDTH-1:0]          gm_rd_data,
  output logic                           lt_wr_en,
  output logic [LT_AW-1:0]               lt_addr,
  output logic [DATA_WIDTH-1:0]          lt_data,
  output logic                           busy,
  output logic                           done,
  output fetch_state_e                   dbg_state
);

  localparam int VW = $clog2(TILE_DIM+1);

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic             load;
  logic             issue;
  logic             pad;
  logic             last;
  logic [LT_AW-1:0] idx;
  logic             pad_q;

  tile_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TILE_DIM   (TILE_DIM),
    .LT_AW      (LT_AW),
    .VW         (VW)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .advance    (issue),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .valid_rows (valid_rows),
    .valid_cols (valid_cols),
    .addr       (gm_addr),
    .idx        (idx),
    .pad        (pad),
    .last       (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic plus the load/issue strobes for the address walker.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (!hold) begin
          issue = 1'b1;
          if (last) state_next = DRAIN;
        end
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write pipeline: one stage matching the global memory read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lt_wr_en <= 1'b0;
      lt_addr  <= '0;
      pad_q    <= 1'b0;
    end else begin
      lt_wr_en <= issue;
      if (issue) begin
        lt_addr <= idx;
        pad_q   <= pad;
      end
    end
  end

  assign gm_rd_en  = issue && !pad;
  assign lt_data   = (lt_wr_en && !pad_q) ? gm_rd_data : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_tile_fetch.sv
// Directed testbench for tile_fetch with a global memory model and a write
// scoreboard; expected padding follows TILE_EDGE_PAD_EN when defined.
module tb_tile_fetch;
  import lstm_mm_pkg::*;

  localparam int DW  = 12;
  localparam int AW  = 9;
  localparam int TD  = 4;
  localparam int N   = TD * TD;
  localparam int LAW = 4;
  localparam int VW  = 3;
`ifdef TILE_EDGE_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           hold = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic [AW-1:0]  row_stride = '0;
  logic [VW-1:0]  valid_rows = '0;
  logic [VW-1:0]  valid_cols = '0;
  logic           gm_rd_en;
  logic [AW-1:0]  gm_addr;
  logic [DW-1:0]  gm_rd_data = '0;
  logic           lt_wr_en;
  logic [LAW-1:0] lt_addr;
  logic [DW-1:0]  lt_data;
  logic           busy;
  logic           done;
  fetch_state_e   dbg_state;

  tile_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hold       (hold),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .valid_rows (valid_rows),
    .valid_cols (valid_cols),
    .gm_rd_en   (gm_rd_en),
    .gm_addr    (gm_addr),
    .gm_rd_data (gm_rd_data),
    .lt_wr_en   (lt_wr_en),
    .lt_addr    (lt_addr),
    .lt_data    (lt_data),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Global memory model: one-cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (gm_rd_en) gm_rd_data <= mem[gm_addr];

  // Scoreboard state
  logic [LAW+DW-1:0] exp_q[$];
  logic [AW-1:0]     exp_addr_q[$];
  int checks = 0;
  int failures = 0;
  int t0 = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int done_k = -1;
  logic [LAW+DW-1:0] got_w, want_w;
  logic [AW-1:0]     want_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: compares writes/reads against the queues and records done pulses
  always @(negedge clk) begin
    if (lt_wr_en) begin
      got_w = {lt_addr, lt_data};
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write got=%0h exp=none", got_w);
      end
      if (exp_q.size() != 0) begin
        want_w = exp_q.pop_front();
        checks++;
        assert (got_w === want_w) else begin
          failures++;
          $error("FAIL write got=%0h exp=%0h", got_w, want_w);
        end
      end
    end
    if (gm_rd_en) begin
      rd_cnt++;
      checks++;
      assert (hold === 1'b0) else begin
        failures++;
        $error("FAIL read_during_hold got=%0b exp=0", gm_rd_en);
      end
      if (exp_addr_q.size() != 0) begin
        want_a = exp_addr_q.pop_front();
        checks++;
        assert (gm_addr === want_a) else begin
          failures++;
          $error("FAIL read_addr got=%0d exp=%0d", gm_addr, want_a);
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_k = cyc - t0;
    end
  end

  // Push expected writes/reads for one tile
  task automatic load_expect(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input logic [VW-1:0] vr, input logic [VW-1:0] vc,
                             output int n_reads);
    logic [AW-1:0] a;
    bit p;
    n_reads = 0;
    exp_q.delete();
    exp_addr_q.delete();
    for (int r = 0; r < TD; r++) begin
      for (int c = 0; c < TD; c++) begin
        a = base + AW'(r) * stride + AW'(c);
        p = PAD_EN && ((r >= int'(vr)) || (c >= int'(vc)));
        if (!p) begin
          exp_addr_q.push_back(a);
          n_reads++;
        end
        exp_q.push_back({LAW'(r*TD + c), p ? DW'(0) : mem[a]});
      end
    end
  endtask

  // Run one fetch for a fixed window and check timing/counts
  task automatic run_fetch(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input logic [VW-1:0] vr, input logic [VW-1:0] vc,
                           input int hold_from, input int hold_len, input int restart_k,
                           input int exp_done);
    int n_reads;
    load_expect(base, stride, vr, vc, n_reads);
    rd_cnt = 0; done_cnt = 0; done_k = -1;
    @(posedge clk); #1;
    base_addr = base; row_stride = stride; valid_rows = vr; valid_cols = vc;
    start = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk); #1;
      start = (k == restart_k);
      hold = (k >= hold_from) && (k < hold_from + hold_len);
      base_addr  = AW'($urandom_range(0, 511));
      row_stride = AW'($urandom_range(0, 511));
      valid_rows = VW'($urandom_range(0, 4));
      valid_cols = VW'($urandom_range(0, 4));
    end
    start = 1'b0; hold = 1'b0;
    chk({tag, "_done_cycle"}, done_k, exp_done);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_read_count"}, rd_cnt, n_reads);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
    chk({tag, "_reads_left"}, exp_addr_q.size(), 0);
    chk({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a);

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gm_rd_en", gm_rd_en, 0);
    chk("rst_gm_addr", gm_addr, 0);
    chk("rst_lt_wr_en", lt_wr_en, 0);
    chk("rst_lt_addr", lt_addr, 0);
    chk("rst_lt_data", lt_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", dbg_state, IDLE);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic fetch
    run_fetch("basic", 9'd0, 9'd16, 3'd4, 3'd4, 100, 0, 0, N + 2);
    // Address wrap-around
    run_fetch("wrap", 9'd500, 9'd16, 3'd4, 3'd4, 100, 0, 0, N + 2);
    // Hold for 3 cycles after element 5 issues (element 5 issues in cycle T+6)
    run_fetch("hold", 9'd37, 9'd20, 3'd4, 3'd4, 7, 3, 0, N + 5);
    // Edge padding
    run_fetch("pad", 9'd64, 9'd16, 3'd3, 3'd2, 100, 0, 0, N + 2);
    // Empty extent
    run_fetch("pad_zero", 9'd10, 9'd8, 3'd0, 3'd4, 100, 0, 0, N + 2);
    // Start during FETCH is ignored
    run_fetch("restart", 9'd200, 9'd32, 3'd4, 3'd4, 100, 0, 5, N + 2);

    // Reset mid-FETCH: pending write dropped, no done
    begin
      int n_reads;
      load_expect(9'd0, 9'd16, 3'd4, 3'd4, n_reads);
      done_cnt = 0;
      @(posedge clk); #1;
      base_addr = 9'd0; row_stride = 9'd16; valid_rows = 3'd4; valid_cols = 3'd4;
      start = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      exp_addr_q.delete();
      chk("mid_rst_gm_rd_en", gm_rd_en, 0);
      chk("mid_rst_gm_addr", gm_addr, 0);
      chk("mid_rst_lt_wr_en", lt_wr_en, 0);
      chk("mid_rst_lt_addr", lt_addr, 0);
      chk("mid_rst_lt_data", lt_data, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_state", dbg_state, IDLE);
      repeat (25) @(posedge clk);
      #1;
      chk("mid_rst_no_done", done_cnt, 0);
    end

    // New start after reset completes normally
    run_fetch("post_rst", 9'd3, 9'd16, 3'd4, 3'd4, 100, 0, 0, N + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
